// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that loads one of INPUTS requesters per cycle into a
// shared single-entry output register with a vld/rd handshake on each side.
module reg_share_arbiter #(
  parameter  int INPUTS     = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int SRC_WIDTH  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*DATA_WIDTH-1:0] req_data,
  input  logic [INPUTS-1:0]            req_vld,
  output logic [INPUTS-1:0]            req_rd,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [SRC_WIDTH-1:0]         dout_src,
  output logic                         dout_vld,
  input  logic                         dout_rd
);

  logic                  full;
  logic [SRC_WIDTH-1:0]  last_grant;
  logic                  grant_vld;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  can_accept;
  logic                  take;

  assign can_accept = !full || dout_rd;
  assign take       = can_accept && grant_vld;
  assign dout_vld   = full;

  // Scan starts one past the last winner, so the most recent grantee is
  // considered last and priority only rotates when a transfer happens.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int k = 1; k <= INPUTS; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % INPUTS;
      if (!grant_vld && req_vld[idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = SRC_WIDTH'(idx);
        grant_data = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_rd = '0;
    if (take) req_rd[grant_idx] = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      dout       <= '0;
      dout_src   <= '0;
      last_grant <= SRC_WIDTH'(INPUTS - 1);
    end else if (take) begin
      full       <= 1'b1;
      dout       <= grant_data;
      dout_src   <= grant_idx;
      last_grant <= grant_idx;
    end else if (dout_rd) begin
      // Consume without refill: payload is left untouched on purpose.
      full <= 1'b0;
    end
  end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Shares one output data register (a D flip-flop bank with valid flag) between INPUTS requesters.
- Each requester presents data under a vld/rd handshake. A round-robin arbiter picks one requester per cycle and loads its data into the shared register.
- The register is exposed downstream as a single-entry buffer with its own vld/rd handshake.
- Sits between several producers and one register consumer. Replaces ad-hoc muxing in front of plain registers.

Parameters:
- INPUTS, 4, number of requesters (>=1).
- DATA_WIDTH, 8, width of each requester's data and of the shared register.
- SRC_WIDTH, max(1, clog2(INPUTS)), width of source index. Derived; must not be overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_data  in  INPUTS*DATA_WIDTH  requester data. Requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_vld  in  INPUTS  requester i has valid data.
- req_rd  out  INPUTS  requester i's data is taken this cycle. At most one bit set.
- dout  out  DATA_WIDTH  shared register contents.
- dout_src  out  SRC_WIDTH  index of the requester that wrote dout.
- dout_vld  out  1  dout holds unconsumed data.
- dout_rd  in  1  downstream consumes dout this cycle.

Behaviour:
- Reset is synchronous, active-high, on clk; clock is clk. While rst=1 at a rising edge:
  - dout<=0, dout_src<=0, dout_vld<=0.
  - last_grant<=INPUTS-1, so requester 0 has top priority after reset.
- Reset overrides any transfer in the same cycle. Data held at that point is dropped. Combinational outputs (req_rd) are not gated by rst.
- Buffer state is the full flag; dout_vld = full.
- can_accept = !full || dout_rd. Combinational.
- Arbitration (combinational):
  - Search indices last_grant+1, last_grant+2, ... modulo INPUTS.
  - grant = first index with req_vld set. No grant if req_vld == 0.
- req_rd[i] = can_accept && grant exists && grant == i. Otherwise 0.
  - req_rd depends combinationally on req_vld and dout_rd.
  - Requesters must not make req_vld depend on req_rd.
- Transfer on requester i (req_rd[i]=1) at a rising edge:
  - dout <= data of requester i.
  - dout_src <= i.
  - full <= 1.
  - last_grant <= i.
- Consume only (full && dout_rd && no transfer): full <= 0. dout and dout_src keep their values; they are don't-care once dout_vld=0, but must not change.
- Consume and transfer in the same cycle: new data is loaded and full stays 1. Gives 1 word/cycle throughput.
- dout_rd while !full is ignored.
- Backpressure (full && !dout_rd):
  - All req_rd=0.
  - dout, dout_src and last_grant remain stable.
- last_grant changes only on a transfer. Idle cycles and stalls do not rotate priority.
- Latency: data accepted at edge N appears on dout with dout_vld=1 immediately after edge N (one register stage).
- Fairness: with all requesters continuously valid and no stalls, the grant sequence is 0,1,...,INPUTS-1,0,...
  - No requester waits more than INPUTS-1 transfers once its vld is asserted.
- Requesters not asserting vld are skipped without costing a cycle.
- INPUTS=1: arbiter degenerates to req_rd[0] = can_accept && req_vld[0]; dout_src constant 0.
- req_data of non-granted requesters has no effect.

Test Plan:
- Reset values: assert rst 2 cycles with all req_vld=1 and dout_rd=1 -> after release, before the first post-reset edge, dout=0, dout_vld=0, dout_src=0, and req_rd=0001 (requester 0 first).
- Round-robin, INPUTS=4, DATA_WIDTH=8, requester i data=0x10+i, all vld=1, dout_rd=1 for 8 cycles:
  - dout sequence 0x10,0x11,0x12,0x13,0x10,... 
  - dout_src 0,1,2,3,0,...
  - dout_vld=1 every cycle after the first.
- Backpressure: load 0x11 from requester 1, then hold dout_rd=0 for 5 cycles with all vld=1:
  - req_rd=0 throughout; dout=0x11, dout_src=1 stable.
  - Release dout_rd -> next grant is requester 2.
- Skip idle requesters: only requesters 0 and 3 valid, dout_rd=1 -> grants alternate 0,3,0,3 with no bubble cycles.
- Drain/idle: single transfer 0x55 from requester 2, then dout_rd=1 with no vld -> dout_vld falls after one cycle, dout stays 0x55. A new vld on requester 1 -> req_rd[1]=1 the same cycle.
- Reset mid-operation: full with 0x12, requester 3 vld, dout_rd=1, rst=1 on the same edge:
  - After the edge: dout_vld=0, dout=0, no transfer recorded.
  - Next grant after release goes to requester 0 if it is valid.
